// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, synchronous-read memory between instruction fetch and load/store.
// Data side has fixed priority; a consecutive-data-grant counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int MAX_DGRANT = 4
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0]      if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  d_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] DMAX = 4'(MAX_DGRANT);

  owner_t     owner;
  logic [3:0] dcnt;
  logic       d_store_q;
  logic       e_if;
  logic       e_d;
  logic       gnt_if;
  logic       gnt_d;

  // Acks and grants are suppressed while rst is high, so an access caught by reset is never acked.
  always_comb begin
    if_ack    = ~rst & (owner == OWN_IF);
    d_ack     = ~rst & (owner == OWN_D);
    if_rdata  = if_ack ? mem_rdata : '0;
    d_rdata   = (d_ack & ~d_store_q) ? mem_rdata : '0;
    e_if      = if_req & ~if_ack;
    e_d       = d_req & ~d_ack;
    gnt_d     = ~rst & e_d & ~(e_if & (dcnt == DMAX));
    gnt_if    = ~rst & e_if & ~gnt_d;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : 4'b0000;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (gnt_if) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      owner     <= OWN_NONE;
      dcnt      <= 4'd0;
      d_store_q <= 1'b0;
    end else begin
      if (gnt_d) begin
        owner     <= OWN_D;
        d_store_q <= d_we;
      end else if (gnt_if) begin
        owner <= OWN_IF;
      end else begin
        owner <= OWN_NONE;
      end
      if (gnt_if || !if_req) begin
        dcnt <= 4'd0;
      end else if (gnt_d && (dcnt != DMAX)) begin
        dcnt <= dcnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a reference model predicts grants and
// read data from the arbitration rules, and a separate monitor checks acked responses.
module tb_mem_port_arbiter;

  localparam int WIDTH    = 32;
  localparam int AW       = 28;
  localparam int MAXD     = 4;
  localparam int OWN_NONE = 0;
  localparam int OWN_IF   = 1;
  localparam int OWN_D    = 2;

  logic             CLK = 1'b0;
  logic             rst;
  logic             if_req;
  logic [AW-1:0]    if_addr;
  logic [WIDTH-1:0] if_rdata;
  logic             if_ack;
  logic             d_req;
  logic             d_we;
  logic [3:0]       d_be;
  logic [AW-1:0]    d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_ack;
  logic             mem_en;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] memRdata = '0;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] tbMem  [0:255];
  logic [31:0] refMem [0:255];
  logic [31:0] macW;
  bit          memLoaded;
  bit          refLoaded;

  logic [31:0] ifQ[$];
  logic [31:0] dQ[$];
  int          ifRd;
  int          dRd;

  bit mIfAck;
  bit mDAck;
  bit ifWaiting;
  bit dWaiting;
  int prevOwner;
  int dStreak;
  int ifWait;
  int dWait;
  bit endReq;
  bit endDone;

  logic [AW-1:0] ifScript[$];
  logic [64:0]   dScript[$];
  bit            ifBusy;
  bit            dBusy;
  int            ifRate;
  int            dRate;

  mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .MAX_DGRANT(MAXD)) dut (
    .CLK(CLK), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(memRdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] initWord(input int i);
    if (i == 1) return 32'h00500093;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [64:0] mkD(input logic we, input logic [3:0] be,
                                      input logic [AW-1:0] addr, input logic [31:0] wd);
    return {we, be, addr, wd};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory macro: byte-masked writes, registered read data one cycle after a read issue.
  always @(posedge CLK) begin : memMacro
    if (!memLoaded) begin
      for (int i = 0; i < 256; i++) tbMem[i] <= initWord(i);
      memLoaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        macW = tbMem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++) if (mem_be[b]) macW[8*b +: 8] = mem_wdata[8*b +: 8];
        tbMem[mem_addr[9:2]] <= macW;
      end else begin
        memRdata <= tbMem[mem_addr[9:2]];
      end
    end
  end

  always @(negedge CLK) begin : refModel
    int          grant;
    bit          eIf;
    bit          eD;
    logic        expEn;
    logic        expWe;
    logic [3:0]  expBe;
    logic [AW-1:0] expAddr;
    logic [31:0] expWd;
    logic [31:0] w;
    if (!refLoaded) begin
      for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
      refLoaded = 1'b1;
    end
    mIfAck = !rst && (prevOwner == OWN_IF);
    mDAck  = !rst && (prevOwner == OWN_D);
    checkOutput("if_ack", 64'(if_ack), 64'(mIfAck));
    checkOutput("d_ack", 64'(d_ack), 64'(mDAck));

    assert (rst || !ifWaiting || if_req) else $error("[TB] fetch request withdrawn before its ack");
    assert (rst || !dWaiting || d_req) else $error("[TB] data request withdrawn before its ack");
    eIf = if_req && !mIfAck;
    eD  = d_req && !mDAck;
    ifWaiting = !rst && eIf;
    dWaiting  = !rst && eD;

    if (rst)                              grant = OWN_NONE;
    else if (eD && eIf && dStreak == MAXD) grant = OWN_IF;
    else if (eD)                          grant = OWN_D;
    else if (eIf)                         grant = OWN_IF;
    else                                  grant = OWN_NONE;

    expEn = 1'b0; expWe = 1'b0; expBe = 4'b0000; expAddr = '0; expWd = '0;
    if (grant == OWN_D) begin
      expEn = 1'b1; expWe = d_we; expBe = d_we ? d_be : 4'b0000;
      expAddr = d_addr; expWd = d_wdata;
    end else if (grant == OWN_IF) begin
      expEn = 1'b1; expAddr = if_addr;
    end
    checkOutput("mem_en", 64'(mem_en), 64'(expEn));
    checkOutput("mem_we", 64'(mem_we), 64'(expWe));
    checkOutput("mem_be", 64'(mem_be), 64'(expBe));
    checkOutput("mem_addr", 64'(mem_addr), 64'(expAddr));
    if (grant != OWN_IF) checkOutput("mem_wdata", 64'(mem_wdata), 64'(expWd));

    if (grant == OWN_IF) ifQ.push_back(refMem[if_addr[9:2]]);
    if (grant == OWN_D) begin
      if (d_we) begin
        w = refMem[d_addr[9:2]];
        for (int b = 0; b < 4; b++) if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
        refMem[d_addr[9:2]] = w;
        dQ.push_back(32'h0);
      end else begin
        dQ.push_back(refMem[d_addr[9:2]]);
      end
    end

    if (rst || grant == OWN_IF || !if_req) dStreak = 0;
    else if (grant == OWN_D && dStreak < MAXD) dStreak++;
    prevOwner = grant;

    if (!rst && if_req && !mIfAck) ifWait++; else ifWait = 0;
    if (!rst && d_req && !mDAck) dWait++; else dWait = 0;
    if (ifWait > 16 || dWait > 16) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL wait_bound: if waited %0d, d waited %0d cycles, required <= 16", ifWait, dWait);
      ifWait = 0;
      dWait = 0;
    end
  end

  // Scoreboard monitor: pops an expected word whenever the DUT presents an ack.
  always @(negedge CLK) begin : monitor
    if (rst) begin
      ifRd = ifQ.size();
      dRd  = dQ.size();
    end else begin
      if (if_ack) begin
        if (ifRd < ifQ.size()) begin
          checkOutput("if_rdata", 64'(if_rdata), 64'(ifQ[ifRd]));
          ifRd++;
        end else checkOutput("if_ack_spurious", 64'(if_ack), 64'(0));
      end else checkOutput("if_rdata_idle", 64'(if_rdata), 64'(0));
      if (d_ack) begin
        if (dRd < dQ.size()) begin
          checkOutput("d_rdata", 64'(d_rdata), 64'(dQ[dRd]));
          dRd++;
        end else checkOutput("d_ack_spurious", 64'(d_ack), 64'(0));
      end else checkOutput("d_rdata_idle", 64'(d_rdata), 64'(0));
    end
    if (endReq && !endDone) begin
      checkOutput("if_queue_drained", 64'(ifQ.size() - ifRd), 64'(0));
      checkOutput("d_queue_drained", 64'(dQ.size() - dRd), 64'(0));
      endDone = 1'b1;
    end
  end

  task automatic applyStimulus(input int n);
    logic [64:0] t;
    repeat (n) begin
      if (ifBusy && mIfAck) ifBusy = 1'b0;
      if (dBusy && mDAck) dBusy = 1'b0;
      if (!ifBusy) begin
        if (ifScript.size() > 0) begin
          if_addr = ifScript.pop_front();
          ifBusy  = 1'b1;
        end else if (ifRate > 0 && int'($urandom_range(99)) < ifRate) begin
          if_addr = {26'($urandom), 2'b00};
          ifBusy  = 1'b1;
        end
      end
      if (!dBusy) begin
        if (dScript.size() > 0) begin
          t = dScript.pop_front();
          {d_we, d_be, d_addr, d_wdata} = t;
          dBusy = 1'b1;
        end else if (dRate > 0 && int'($urandom_range(99)) < dRate) begin
          d_we    = 1'($urandom);
          d_be    = 4'($urandom);
          d_addr  = 28'($urandom);
          d_wdata = $urandom;
          dBusy   = 1'b1;
        end
      end
      if_req = ifBusy;
      d_req  = dBusy;
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    ifRate = 0; dRate = 0;
    @(posedge CLK);
    #1;
    // Both requests held through reset; data side must win the first cycle after it.
    ifScript.push_back(28'h004);
    dScript.push_back(mkD(1'b0, 4'hF, 28'h040, 32'h0));
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(6);
    dScript.push_back(mkD(1'b1, 4'hF, 28'h100, 32'hDEADBEEF));
    dScript.push_back(mkD(1'b0, 4'h0, 28'h100, 32'h0));
    applyStimulus(8);
    ifRate = 100; dRate = 100;
    applyStimulus(40);
    ifRate = 0; dRate = 0;
    applyStimulus(6);
    // Fetch arrives in the d_ack cycle and must issue in that same cycle.
    dScript.push_back(mkD(1'b0, 4'h0, 28'h200, 32'h0));
    applyStimulus(1);
    ifScript.push_back(28'h008);
    applyStimulus(6);
    dScript.push_back(mkD(1'b0, 4'h0, 28'h080, 32'h0));
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(6);
    ifRate = 50; dRate = 50;
    repeat (1500) begin
      rst = ($urandom_range(199) == 0);
      applyStimulus(1);
    end
    rst = 1'b0; ifRate = 0; dRate = 0;
    applyStimulus(10);
    endReq = 1'b1;
    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported, synchronous-read unified memory between the CPU instruction-fetch requester and the load/store requester. It sits between the PC/instruction-fetch path and the data-memory path on one side and a shared memory macro on the other. It issues at most one access per cycle and returns read data and an acknowledge one cycle after issue. It uses fixed data-side priority with a starvation guard, so fetch always makes progress.

## Interface
Parameters:
- `WIDTH`, 32, data width of all data buses.
- `ADDR_WIDTH`, 28, byte address width, matching the `PC[27:0]` fetch address.
- `MAX_DGRANT`, 4, maximum consecutive data grants while a fetch is pending. Legal range 1–15.

Ports:
- `CLK`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request. Held with `if_addr` stable until `if_ack`.
- `if_addr`  in  ADDR_WIDTH  fetch byte address, word-aligned.
- `if_rdata`  out  WIDTH  fetched word. Valid only while `if_ack`=1.
- `if_ack`  out  1  one-cycle pulse: the fetch access is complete.
- `d_req`  in  1  data request. Held with all `d_*` inputs stable until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  4  byte enables for a store (from `Type`). Ignored for loads.
- `d_addr`  in  ADDR_WIDTH  data byte address.
- `d_wdata`  in  WIDTH  store data, already lane-aligned.
- `d_rdata`  out  WIDTH  load word. Valid only while `d_ack`=1.
- `d_ack`  out  1  one-cycle pulse: the load/store access is complete.
- `mem_en`  out  1  memory access strobe this cycle.
- `mem_we`  out  1  write strobe. Asserted only with `mem_en`.
- `mem_be`  out  4  byte enables. 4'b0000 when `mem_we`=0.
- `mem_addr`  out  ADDR_WIDTH  access address.
- `mem_wdata`  out  WIDTH  write data.
- `mem_rdata`  in  WIDTH  read data, valid the cycle after a read issue.

## Operation
- State is the registered owner of the last-cycle issue: `NONE`, `IF`, or `D`. It is `NONE` after reset.
- **Ack generation:**
  - Owner `IF` this cycle: `if_ack`=1 and `if_rdata`=`mem_rdata`.
  - Owner `D` this cycle: `d_ack`=1. For a load, `d_rdata`=`mem_rdata`. For a store, `d_rdata`=0.
- **Masking:** in the cycle a requester is acked, its `req` is masked from arbitration. The requester must then deassert or present a new request at the following edge.
- **Eligibility:** `e_if` = `if_req` & ~`if_ack`. `e_d` = `d_req` & ~`d_ack`.
- **Grant, evaluated combinationally each cycle:**
  - `e_d` & `e_if` & (`dcnt` == `MAX_DGRANT`) → grant IF.
  - Otherwise `e_d` → grant D.
  - Otherwise `e_if` → grant IF.
  - Otherwise no grant.
- **Memory drive:**
  - Grant D: `mem_en`=1, `mem_we`=`d_we`, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`, `mem_be`=`d_we` ? `d_be` : 0.
  - Grant IF: `mem_en`=1, `mem_we`=0, `mem_addr`=`if_addr`.
  - No grant: all `mem_*` outputs are 0.
- **Next owner:** the grant of this cycle becomes next cycle's owner. No grant → `NONE`.
- **Starvation counter `dcnt` (4 bits):**
  - Increments on a D grant while `if_req`=1, saturating at `MAX_DGRANT`.
  - Clears on any IF grant, and when `if_req`=0.
- Throughput is 1 access per cycle when the requesters alternate. A single requester issuing back-to-back gets 1 access per 2 cycles.

## Timing
- Issue at cycle t (combinational `mem_*` outputs) → ack at t+1 (registered owner, combinational data passthrough).
- Fixed latency of 1. No other wait states.
- Reset values:
  - Owner `NONE`, `dcnt`=0.
  - `if_ack`=0, `d_ack`=0.
  - `if_rdata` and `d_rdata` are 0 while no ack.
  - All `mem_*` outputs are 0 whenever no request is present.
- Simultaneous requests in a cycle with no ack: D wins unless `dcnt` == `MAX_DGRANT`.
- Ack to one side and a request from the other in the same cycle: the other side is issued in that cycle (overlapped).
- Reset mid-access: an access issued at cycle t with `rst`=1 at t+1 is never acked. Owner becomes `NONE` and requesters re-request after reset.
- A request withdrawn before its ack is a protocol violation; the outcome is undefined. The bench flags it with an assertion.
- A store in flight is acked at t+1. A same-address load granted at t+1 reads the new data at t+2.

## Test plan
- **Reset:** hold `rst` 2 cycles with both requests high → `mem_en`=0, both acks 0. First grant is D in the cycle after `rst` falls.
- **Single fetch:** `if_req`=1, `if_addr`=0x004, memory word 0x00500093 → `mem_en`=1 with `mem_addr`=0x004 at t. `if_ack`=1 and `if_rdata`=0x00500093 at t+1, `d_ack`=0.
- **Store then load:** store `d_be`=4'b1111 of 0xDEADBEEF to 0x100, then a load from 0x100 → `mem_we`=1 and `mem_be`=4'hF at issue. `d_ack` on the next cycle. The load returns 0xDEADBEEF.
- **Contention:** both requests held continuously with `MAX_DGRANT`=4 and the data side re-requesting every cycle it is allowed → grant sequence D,–,D,–,… with an IF grant inserted no later than after the 4th D grant. `if_ack` follows one cycle later and `dcnt` returns to 0.
- **Overlap:** `if_req` asserted in a `d_ack` cycle → IF issued in that same cycle, `if_ack` the next cycle. Zero idle cycles between the two accesses.
- **Reset mid-access:** a D load issued, then `rst`=1 in the following cycle → `d_ack` stays 0, owner is `NONE`, and no `mem_en` is asserted while `rst`=1 and no request is present.
